seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 219 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle integer ops plus optional iterative multiply/divide.
// Define SEQ_ALU_MULDIV_EN to build the multi-cycle MUL/DIV datapath and states.
module seq_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [5:0]            ALU_Control,
    input  logic [DATA_WIDTH-1:0] operand_A,
    input  logic [DATA_WIDTH-1:0] operand_B,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ALU_result,
    output logic                  zero,
    output logic                  branch
);
    localparam int SW = $clog2(DATA_WIDTH);

    logic                  accept;
    logic [SW-1:0]         shamt;
    logic signed [DATA_WIDTH-1:0] a_signed;
    logic                  eq, lt_s, lt_u;
    logic [DATA_WIDTH-1:0] single_result;
    logic [DATA_WIDTH-1:0] result_reg;
    logic                  done_reg;
    logic [5:0]            code_reg;

    assign accept   = start & ready;
    assign shamt    = operand_B[SW-1:0];
    assign a_signed = operand_A;
    assign eq       = (operand_A == operand_B);
    assign lt_s     = ($signed(operand_A) < $signed(operand_B));
    assign lt_u     = (operand_A < operand_B);

    always_comb begin
        single_result = '0;
        case (ALU_Control)
            6'b000000: single_result = operand_A + operand_B;
            6'b001000: single_result = operand_A - operand_B;
            6'b000100: single_result = operand_A ^ operand_B;
            6'b000110: single_result = operand_A | operand_B;
            6'b000111: single_result = operand_A & operand_B;
            6'b000010: single_result = DATA_WIDTH'(lt_s);
            6'b000011: single_result = DATA_WIDTH'(lt_u);
            6'b000001: single_result = operand_A << shamt;
            6'b000101: single_result = operand_A >> shamt;
            6'b001101: single_result = a_signed >>> shamt;
            6'b011111: single_result = operand_A;
            6'b010000: single_result = DATA_WIDTH'(eq);
            6'b010001: single_result = DATA_WIDTH'(!eq);
            6'b010100: single_result = DATA_WIDTH'(lt_s);
            6'b010101: single_result = DATA_WIDTH'(!lt_s);
            6'b010110: single_result = DATA_WIDTH'(lt_u);
            6'b010111: single_result = DATA_WIDTH'(!lt_u);
            default:   single_result = '0;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   hi_reg, lo_reg, mag_reg, hi_next, lo_next;
    logic [SW-1:0]           cnt_reg;
    logic                    neg_reg;
    logic [5:0]              op_reg;
    logic                    is_mul, is_div, div_zero, div_ovf;
    logic                    sign_a, sign_b, a_neg, b_neg, neg_start;
    logic [DATA_WIDTH-1:0]   a_mag, b_mag, div_special;
    logic                    start_mul, start_div, fast_done, last_step;
    logic [DATA_WIDTH-1:0]   fast_result, final_result;
    logic [DATA_WIDTH:0]     mul_sum, div_shift;
    logic                    div_ge;
    logic [2*DATA_WIDTH-1:0] prod, prod_s;
    logic [DATA_WIDTH-1:0]   quo_s, rem_s;

    assign is_mul   = (ALU_Control[5:2] == 4'b1000);
    assign is_div   = (ALU_Control[5:2] == 4'b1001);
    assign div_zero = (operand_B == '0);
    assign div_ovf  = !ALU_Control[0] && (operand_A == MOST_NEG) && (&operand_B);
    assign sign_a   = is_mul ? (ALU_Control[1:0] == 2'b01 || ALU_Control[1:0] == 2'b10) : !ALU_Control[0];
    assign sign_b   = is_mul ? (ALU_Control[1:0] == 2'b01) : !ALU_Control[0];
    assign a_neg    = sign_a & operand_A[DATA_WIDTH-1];
    assign b_neg    = sign_b & operand_B[DATA_WIDTH-1];
    assign a_mag    = a_neg ? -operand_A : operand_A;
    assign b_mag    = b_neg ? -operand_B : operand_B;
    // Remainder takes the dividend's sign; quotients and products take the XOR.
    assign neg_start = (is_div && ALU_Control[1]) ? a_neg : (a_neg ^ b_neg);
    assign div_special = div_zero ? (ALU_Control[1] ? operand_A : '1)
                                  : (ALU_Control[1] ? '0 : operand_A);

    assign ready = (state_reg == IDLE);

    always_comb begin
        state_next  = state_reg;
        start_mul   = 1'b0;
        start_div   = 1'b0;
        fast_done   = 1'b0;
        last_step   = 1'b0;
        fast_result = single_result;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_next = MUL;
                        start_mul  = 1'b1;
                    end else if (is_div && !div_zero && !div_ovf) begin
                        state_next = DIV;
                        start_div  = 1'b1;
                    end else begin
                        fast_done   = 1'b1;
                        fast_result = is_div ? div_special : single_result;
                    end
                end
            end
            MUL, DIV: begin
                if (cnt_reg == SW'(DATA_WIDTH - 1)) begin
                    state_next = IDLE;
                    last_step  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // hi/lo hold {partial product, multiplier} or {remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, hi_reg} + {1'b0, (lo_reg[0] ? mag_reg : {DATA_WIDTH{1'b0}})};
    assign div_shift = {hi_reg, lo_reg[DATA_WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, mag_reg});

    always_comb begin
        if (state_reg == MUL) begin
            hi_next = mul_sum[DATA_WIDTH:1];
            lo_next = {mul_sum[0], lo_reg[DATA_WIDTH-1:1]};
        end else begin
            hi_next = div_ge ? (div_shift[DATA_WIDTH-1:0] - mag_reg) : div_shift[DATA_WIDTH-1:0];
            lo_next = {lo_reg[DATA_WIDTH-2:0], div_ge};
        end
    end

    assign prod   = {hi_next, lo_next};
    assign prod_s = neg_reg ? -prod : prod;
    assign quo_s  = neg_reg ? -lo_next : lo_next;
    assign rem_s  = neg_reg ? -hi_next : hi_next;

    always_comb begin
        if (state_reg == MUL)
            final_result = (op_reg[1:0] == 2'b00) ? prod_s[DATA_WIDTH-1:0] : prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
        else
            final_result = op_reg[1] ? rem_s : quo_s;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            done_reg   <= 1'b0;
            code_reg   <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            mag_reg    <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            op_reg     <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            if (fast_done) begin
                result_reg <= fast_result;
                done_reg   <= 1'b1;
                code_reg   <= ALU_Control;
            end
            if (start_mul || start_div) begin
                hi_reg  <= '0;
                lo_reg  <= start_mul ? b_mag : a_mag;
                mag_reg <= start_mul ? a_mag : b_mag;
                cnt_reg <= '0;
                neg_reg <= neg_start;
                op_reg  <= ALU_Control;
            end
            if (state_reg != IDLE) begin
                hi_reg  <= hi_next;
                lo_reg  <= lo_next;
                cnt_reg <= cnt_reg + 1'b1;
                if (last_step) begin
                    result_reg <= final_result;
                    done_reg   <= 1'b1;
                    code_reg   <= op_reg;
                end
            end
        end
    end
`else
    assign ready = 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            result_reg <= '0;
            done_reg   <= 1'b0;
            code_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                result_reg <= single_result;
                done_reg   <= 1'b1;
                code_reg   <= ALU_Control;
            end
        end
    end
`endif

    assign done       = done_reg;
    assign ALU_result = result_reg;
    assign zero       = (result_reg == '0);
    assign branch     = (code_reg[4:3] == 2'b10) && (result_reg == DATA_WIDTH'(1));
endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against an arithmetic reference model.
// Honors SEQ_ALU_MULDIV_EN the same way the design does.
module tb_seq_alu;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  ALU_Control;
    logic [31:0] operand_A;
    logic [31:0] operand_B;
    logic        ready;
    logic        done;
    logic [31:0] ALU_result;
    logic        zero;
    logic        branch;

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0] sc_codes [17] = '{6'b000000, 6'b001000, 6'b000100, 6'b000110, 6'b000111,
                                  6'b000010, 6'b000011, 6'b000001, 6'b000101, 6'b001101,
                                  6'b011111, 6'b010000, 6'b010001, 6'b010100, 6'b010101,
                                  6'b010110, 6'b010111};

    seq_alu #(.DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .ALU_Control(ALU_Control),
        .operand_A(operand_A), .operand_B(operand_B), .ready(ready), .done(done),
        .ALU_result(ALU_result), .zero(zero), .branch(branch)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      p;
        logic [63:0] pu;
        logic [4:0]  sh;
        logic        ovf;
        sa  = a;
        sb  = b;
        sh  = b[4:0];
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            6'b000000: return a + b;
            6'b001000: return a - b;
            6'b000100: return a ^ b;
            6'b000110: return a | b;
            6'b000111: return a & b;
            6'b000010: return (sa < sb) ? 32'd1 : 32'd0;
            6'b000011: return (a < b) ? 32'd1 : 32'd0;
            6'b000001: return a << sh;
            6'b000101: return a >> sh;
            6'b001101: return 32'(sa >>> sh);
            6'b011111: return a;
            6'b010000: return (a == b) ? 32'd1 : 32'd0;
            6'b010001: return (a != b) ? 32'd1 : 32'd0;
            6'b010100: return (sa < sb) ? 32'd1 : 32'd0;
            6'b010101: return (sa >= sb) ? 32'd1 : 32'd0;
            6'b010110: return (a < b) ? 32'd1 : 32'd0;
            6'b010111: return (a >= b) ? 32'd1 : 32'd0;
`ifdef SEQ_ALU_MULDIV_EN
            6'b100000: return a * b;
            6'b100001: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            6'b100010: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
            6'b100011: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            6'b100100: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            6'b100101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            6'b100110: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            6'b100111: return (b == 0) ? a : a % b;
`endif
            default:   return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_ALU_MULDIV_EN
        if (op[5:3] == 3'b100) begin
            if (op[2] == 1'b0) return 33;
            if (b == 0) return 1;
            if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`endif
        return 1;
    endfunction

    // Called and returns just after a falling edge; poke drives ignored starts while busy.
    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [31:0] exp;
        int          lat;
        exp = ref_model(op, a, b);
        lat = ref_latency(op, a, b);
        check_value("ready_idle", 32'(ready), 32'd1);
        start = 1'b1; ALU_Control = op; operand_A = a; operand_B = b;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c < lat; c++) begin
            check_value("ready_busy", 32'(ready), 32'd0);
            check_value("done_busy", 32'(done), 32'd0);
            if (poke) begin
                start = 1'b1; ALU_Control = 6'b000000; operand_A = $urandom; operand_B = $urandom;
            end
            @(negedge clock);
            start = 1'b0;
        end
        check_value("done", 32'(done), 32'd1);
        check_value("result", ALU_result, exp);
        check_value("zero", 32'(zero), (exp == 0) ? 32'd1 : 32'd0);
        check_value("branch", 32'(branch), (op[4:3] == 2'b10 && exp == 1) ? 32'd1 : 32'd0);
        check_value("ready_done", 32'(ready), 32'd1);
        $display("op=%b a=%h b=%h lat=%0d result=%h", op, a, b, lat, ALU_result);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0]  op, prev_op;
        logic [31:0] a, b, prev_a, prev_b;
        reset = 1'b1; start = 1'b0; ALU_Control = '0; operand_A = '0; operand_B = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_result", ALU_result, 32'd0);
        check_value("rst_ready", 32'(ready), 32'd1);
        check_value("rst_zero", 32'(zero), 32'd1);
        check_value("rst_branch", 32'(branch), 32'd0);

        do_op(6'b000000, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op(6'b001101, 32'h8000_0000, 32'd4, 1'b0);
        do_op(6'b000010, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op(6'b000011, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op(6'b100001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_op(6'b100011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_op(6'b100100, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(6'b100110, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(6'b100101, 32'd5, 32'd0, 1'b0);
        do_op(6'b100100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(6'b100110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(6'b010101, 32'd3, 32'd3, 1'b0);
        do_op(6'b111000, 32'd9, 32'd9, 1'b0);

        // Reset mid-operation must abort without a completion pulse.
        start = 1'b1; ALU_Control = 6'b100101; operand_A = 32'd1000; operand_B = 32'd7;
        @(negedge clock);
        start = 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
        for (int c = 1; c < 10; c++) begin
            check_value("abort_busy_done", 32'(done), 32'd0);
            @(negedge clock);
        end
`endif
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_value("abort_done", 32'(done), 32'd0);
        check_value("abort_ready", 32'(ready), 32'd1);
        check_value("abort_result", ALU_result, 32'd0);
        for (int c = 0; c < 35; c++) begin
            @(negedge clock);
            check_value("abort_quiet", 32'(done), 32'd0);
        end
        $display("reset during DIVU: result=%h ready=%b", ALU_result, ready);

        // Reset wins over a simultaneous start.
        do_op(6'b000000, 32'd5, 32'd6, 1'b0);
        reset = 1'b1; start = 1'b1; ALU_Control = 6'b000000; operand_A = 32'd7; operand_B = 32'd8;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        check_value("rst_start_done", 32'(done), 32'd0);
        check_value("rst_start_result", ALU_result, 32'd0);
        $display("reset with start: result=%h done=%b", ALU_result, done);

        // Back-to-back single-cycle ops: one completion per cycle.
        prev_op = '0; prev_a = '0; prev_b = '0;
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) begin
                check_value("b2b_done", 32'(done), 32'd1);
                check_value("b2b_result", ALU_result, ref_model(prev_op, prev_a, prev_b));
                $display("b2b op=%b a=%h b=%h result=%h", prev_op, prev_a, prev_b, ALU_result);
            end
            if (i < 20) begin
                op = sc_codes[$urandom_range(0, 16)];
                a = pick_operand();
                b = pick_operand();
                start = 1'b1; ALU_Control = op; operand_A = a; operand_B = b;
                prev_op = op; prev_a = a; prev_b = b;
                @(negedge clock);
            end
        end
        start = 1'b0;
        @(negedge clock);
        check_value("b2b_idle_done", 32'(done), 32'd0);

        for (int i = 0; i < 150; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 6)      op = sc_codes[$urandom_range(0, 16)];
            else if (sel < 9) op = {3'b100, 3'($urandom_range(0, 7))};
            else              op = 6'($urandom);
            a = pick_operand();
            b = pick_operand();
            do_op(op, a, b, 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clock);
                check_value("idle_done", 32'(done), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
